// File: rtl/sobel_pkg.sv
// Shared widths, saturation limit, kernel-select enum and small arithmetic helpers
// for the Sobel edge stage.
package sobel_pkg;
    localparam int DATA_W  = 12;
    localparam int LUMA_W  = 14;
    localparam int GRAD_W  = 15;
    localparam int SAT_MAX = 4095;

    typedef enum logic {KERN_VERT = 1'b0, KERN_HORZ = 1'b1} kern_e;

    // Y = (R + 2G + B) >> 2; the 14-bit sum cannot overflow (max 16380).
    function automatic logic [DATA_W-1:0] luma(input logic [DATA_W-1:0] r,
                                               input logic [DATA_W-1:0] g,
                                               input logic [DATA_W-1:0] b);
        logic [LUMA_W-1:0] sum;
        sum = LUMA_W'(r) + LUMA_W'({g, 1'b0}) + LUMA_W'(b);
        return sum[LUMA_W-1:2];
    endfunction

    function automatic logic signed [GRAD_W-1:0] widen(input logic [DATA_W-1:0] v);
        return $signed(GRAD_W'(v));
    endfunction
endpackage

// File: rtl/sobel_line_buffer.sv
// One-line Y delay (DEPTH enabled samples, one tap); contents are never reset.
// Zero extra latency beyond DEPTH; no backpressure, advances only when en_i is high.
module sobel_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 12
) (
    input  logic             core_clk_i,
    input  logic             arst_n_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] tap_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr_q;
    logic [AW-1:0]    ptr_d;

    // Read-before-write at the same slot gives exactly DEPTH samples of delay.
    assign tap_o = mem[ptr_q];
    assign ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;

    always_ff @(posedge core_clk_i) begin
        if (en_i) begin
            mem[ptr_q] <= din_i;
        end
    end

    always_ff @(posedge core_clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/sobel_edge_filter.sv
// 3x3 Sobel gradient magnitude on luma (or RGB bypass), fixed 3-cycle latency iDVAL->oDVAL.
// No backpressure: every stage advances each cycle, bubbles travel as oDVAL low.
module sobel_edge_filter #(
    parameter int LINE_WIDTH = 640,
    parameter int DATA_W     = 12
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iRed,
    input  logic [DATA_W-1:0] iGreen,
    input  logic [DATA_W-1:0] iBlue,
    input  logic              iDVAL,
    input  logic [10:0]       iX_Cont,
    input  logic [10:0]       iY_Cont,
    input  logic              iEdgeDetect,
    input  logic              iIsHorizontalEdge,
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue,
    output logic              oDVAL
);
    import sobel_pkg::*;

    localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

    logic              frame_start;
    logic [CW-1:0]     col_q, col_d, col_cur;
    logic [10:0]       row_q, row_d, row_cur;
    logic              edge_q, edge_d;
    kern_e             kern_q, kern_d;
    logic [DATA_W-1:0] y_cur, lb1_tap, lb2_tap;

    logic [DATA_W-1:0]   win_q [3][3];
    logic [3*DATA_W-1:0] rgb1_q, rgb2_q;
    logic                dval1_q, dval2_q;
    logic                edge1_q, edge2_q;
    logic                inner1_q, inner2_q;
    kern_e               kern1_q;

    logic signed [GRAD_W-1:0] row0_s, row2_s, col0_s, col2_s, grad_d, grad_q;
    logic [GRAD_W-1:0]        mag;
    logic [DATA_W-1:0]        edge_val;

    // The frame-start cycle itself is pixel (0,0) and already uses the newly latched mode.
    always_comb begin
        frame_start = (iX_Cont == 11'd0) && (iY_Cont == 11'd0);
        col_cur     = frame_start ? '0 : col_q;
        row_cur     = frame_start ? '0 : row_q;
        y_cur       = luma(iRed, iGreen, iBlue);

        col_d  = col_cur;
        row_d  = row_cur;
        edge_d = edge_q;
        kern_d = kern_q;
        if (frame_start) begin
            edge_d = iEdgeDetect;
            kern_d = kern_e'(iIsHorizontalEdge);
        end
        if (iDVAL) begin
            if (col_cur == CW'(LINE_WIDTH - 1)) begin
                col_d = '0;
                if (row_cur != 11'h7FF) begin
                    row_d = row_cur + 1'b1;
                end
            end else begin
                col_d = col_cur + 1'b1;
            end
        end
    end

    sobel_line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(DATA_W)) u_lb_prev (
        .core_clk_i (iCLK),
        .arst_n_i   (iRST),
        .en_i       (iDVAL),
        .din_i      (y_cur),
        .tap_o      (lb1_tap)
    );

    sobel_line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(DATA_W)) u_lb_old (
        .core_clk_i (iCLK),
        .arst_n_i   (iRST),
        .en_i       (iDVAL),
        .din_i      (lb1_tap),
        .tap_o      (lb2_tap)
    );

    always_comb begin
        row0_s = widen(win_q[0][0]) + (widen(win_q[0][1]) <<< 1) + widen(win_q[0][2]);
        row2_s = widen(win_q[2][0]) + (widen(win_q[2][1]) <<< 1) + widen(win_q[2][2]);
        col0_s = widen(win_q[0][0]) + (widen(win_q[1][0]) <<< 1) + widen(win_q[2][0]);
        col2_s = widen(win_q[0][2]) + (widen(win_q[1][2]) <<< 1) + widen(win_q[2][2]);
        grad_d = (kern1_q == KERN_HORZ) ? (row0_s - row2_s) : (col2_s - col0_s);
    end

    always_comb begin
        mag      = grad_q[GRAD_W-1] ? $unsigned(-grad_q) : $unsigned(grad_q);
        edge_val = (mag > GRAD_W'(SAT_MAX)) ? DATA_W'(SAT_MAX) : mag[DATA_W-1:0];
        if (!inner2_q) begin
            edge_val = '0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col_q    <= '0;
            row_q    <= '0;
            edge_q   <= 1'b0;
            kern_q   <= KERN_VERT;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
            rgb1_q   <= '0;
            rgb2_q   <= '0;
            dval1_q  <= 1'b0;
            dval2_q  <= 1'b0;
            edge1_q  <= 1'b0;
            edge2_q  <= 1'b0;
            inner1_q <= 1'b0;
            inner2_q <= 1'b0;
            kern1_q  <= KERN_VERT;
            grad_q   <= '0;
            oRed     <= '0;
            oGreen   <= '0;
            oBlue    <= '0;
            oDVAL    <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            edge_q   <= edge_d;
            kern_q   <= kern_d;

            // Stage 1: luma into window; mode and border flag travel with the pixel.
            dval1_q  <= iDVAL;
            rgb1_q   <= {iRed, iGreen, iBlue};
            edge1_q  <= edge_d;
            kern1_q  <= kern_d;
            inner1_q <= (row_cur >= 11'd2) && (col_cur >= CW'(2));
            if (iDVAL) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= lb2_tap;
                win_q[1][2] <= lb1_tap;
                win_q[2][2] <= y_cur;
            end

            // Stage 2: kernel sums.
            dval2_q  <= dval1_q;
            rgb2_q   <= rgb1_q;
            edge2_q  <= edge1_q;
            inner2_q <= inner1_q;
            grad_q   <= grad_d;

            // Stage 3: abs, saturate, select.
            oDVAL    <= dval2_q;
            if (edge2_q) begin
                oRed   <= edge_val;
                oGreen <= edge_val;
                oBlue  <= edge_val;
            end else begin
                {oRed, oGreen, oBlue} <= rgb2_q;
            end
        end
    end
endmodule

// File: tb/tb_sobel_edge_filter.sv
// Randomised frames against an image-level Sobel/bypass reference model.
module tb_sobel_edge_filter;
    localparam int LW   = 16;
    localparam int ROWS = 8;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [11:0] iRed = '0, iGreen = '0, iBlue = '0;
    logic        iDVAL = 1'b0;
    logic [10:0] iX_Cont = 11'h7FF, iY_Cont = 11'h7FF;
    logic        iEdgeDetect = 1'b0, iIsHorizontalEdge = 1'b0;
    logic [11:0] oRed, oGreen, oBlue;
    logic        oDVAL;

    sobel_edge_filter #(.LINE_WIDTH(LW), .DATA_W(12)) dut (
        .iCLK              (iCLK),
        .iRST              (iRST),
        .iRed              (iRed),
        .iGreen            (iGreen),
        .iBlue             (iBlue),
        .iDVAL             (iDVAL),
        .iX_Cont           (iX_Cont),
        .iY_Cont           (iY_Cont),
        .iEdgeDetect       (iEdgeDetect),
        .iIsHorizontalEdge (iIsHorizontalEdge),
        .oRed              (oRed),
        .oGreen            (oGreen),
        .oBlue             (oBlue),
        .oDVAL             (oDVAL)
    );

    always #5 iCLK = ~iCLK;

    typedef struct { int r; int g; int b; } pix_t;

    pix_t exp_q[$];
    pix_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   ymem [0:15][0:LW-1];
    int   m_r = 0, m_c = 0;
    bit   m_edge = 0, m_horz = 0;
    bit   edge_in = 0, horz_in = 0;
    logic [2:0] hist;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Gradient magnitude of the 3x3 neighbourhood whose newest pixel is (r,c).
    function automatic int sobel_ref(input int r, input int c, input bit horz);
        int p [3][3];
        int g;
        if (r < 2 || c < 2) return 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = ymem[r-2+i][c-2+j];
        if (horz) g = (p[0][0] + 2*p[0][1] + p[0][2]) - (p[2][0] + 2*p[2][1] + p[2][2]);
        else      g = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        if (g < 0) g = -g;
        return (g > 4095) ? 4095 : g;
    endfunction

    // One input cycle; updates the reference model, then advances to #1 after the edge.
    task automatic drive(input bit vld, input bit fs, input int r, input int g, input int b);
        pix_t e;
        int   v;
        iDVAL             = vld;
        iRed              = 12'(r);
        iGreen            = 12'(g);
        iBlue             = 12'(b);
        iEdgeDetect       = edge_in;
        iIsHorizontalEdge = horz_in;
        iX_Cont           = fs ? 11'd0 : 11'(m_c + 1);
        iY_Cont           = fs ? 11'd0 : 11'(m_r + 1);
        if (fs) begin
            m_r = 0; m_c = 0; m_edge = edge_in; m_horz = horz_in;
        end
        if (vld) begin
            ymem[m_r][m_c] = (r + 2*g + b) / 4;
            if (m_edge) begin
                v = sobel_ref(m_r, m_c, m_horz);
                e.r = v; e.g = v; e.b = v;
            end else begin
                e.r = r; e.g = g; e.b = b;
            end
            exp_q.push_back(e);
            m_c++;
            if (m_c == LW) begin
                m_c = 0;
                if (m_r < 2047) m_r++;
            end
        end
        @(posedge iCLK);
        #1;
    endtask

    // img: 0 random, 1 flat 1000, 2 vertical step, 3 horizontal step, 4 fixed 100/200/300.
    // fsm: 0 frame start on first pixel, 1 frame start on a bubble, 2 no frame start.
    task automatic frame(input int img, input int npix, input int fsm, input int toggle_at);
        int r, g, b, pr, pc;
        if (fsm == 1) drive(0, 1, 0, 0, 0);
        for (int n = 0; n < npix; n++) begin
            pr = n / LW;
            pc = n % LW;
            case (img)
                0: begin
                    r = int'($urandom_range(0, 4095));
                    g = int'($urandom_range(0, 4095));
                    b = int'($urandom_range(0, 4095));
                end
                1: begin r = 1000; g = 1000; b = 1000; end
                2: begin r = (pc >= LW/2) ? 4095 : 0; g = r; b = r; end
                3: begin r = (pr >= ROWS/2) ? 1000 : 0; g = r; b = r; end
                default: begin r = 100; g = 200; b = 300; end
            endcase
            if (n == toggle_at) horz_in = !horz_in;
            if ($urandom_range(0, 3) == 0) drive(0, 0, 0, 0, 0);
            drive(1, (n == 0) && (fsm == 0), r, g, b);
        end
    endtask

    always @(posedge iCLK or negedge iRST) begin
        if (!iRST) hist <= '0;
        else       hist <= {hist[1:0], iDVAL};
    end

    always @(negedge iCLK) begin
        check("odval", int'(oDVAL), int'(hist[2]));
        if (oDVAL) begin
            check("exp_avail", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("red",   int'(oRed),   mon_e.r);
                check("green", int'(oGreen), mon_e.g);
                check("blue",  int'(oBlue),  mon_e.b);
            end
        end
    end

    initial begin
        #1 iRST = 1'b0;
        #1;
        check("rst_red",   int'(oRed),   0);
        check("rst_green", int'(oGreen), 0);
        check("rst_blue",  int'(oBlue),  0);
        check("rst_dval",  int'(oDVAL),  0);
        repeat (3) @(posedge iCLK);
        #1 iRST = 1'b1;

        edge_in = 0; horz_in = 0;
        frame(4, 20, 0, -1);
        frame(0, 40, 0, -1);

        // Asynchronous reset mid-stream; the following pixels restart at (0,0) in bypass.
        #2 iRST = 1'b0;
        #1;
        check("arst_red",   int'(oRed),   0);
        check("arst_green", int'(oGreen), 0);
        check("arst_blue",  int'(oBlue),  0);
        check("arst_dval",  int'(oDVAL),  0);
        exp_q.delete();
        m_r = 0; m_c = 0; m_edge = 0; m_horz = 0;
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        iRST = 1'b1;
        edge_in = 1; horz_in = 1;
        frame(0, 24, 2, -1);

        frame(1, LW*5, 0, -1);
        horz_in = 0;
        frame(1, LW*5, 1, -1);
        frame(2, LW*ROWS, 0, -1);
        horz_in = 1;
        frame(2, LW*ROWS, 0, -1);
        frame(3, LW*ROWS - 1, 0, -1);
        horz_in = 0;
        frame(0, LW*6, 0, 40);
        frame(0, LW*4, 1, -1);
        edge_in = 0;
        frame(0, LW*2, 0, -1);

        repeat (6) drive(0, 0, 0, 0, 0);
        check("drain_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/sobel_edge_filter.md
# sobel_edge_filter

Streaming 3x3 Sobel edge-detection stage that sits directly downstream of the Bayer-to-RGB demosaic. It consumes that stage's 12-bit RGB pixel stream and reduces each pixel to luma. It computes either the horizontal-edge or the vertical-edge gradient magnitude over a two-line window and drives the result on all three colour channels toward the display/SDRAM path. With edge detection disabled, it passes RGB through with identical latency.

## Interface
Parameters:
- `LINE_WIDTH`, default 640: valid pixels per line at the input, post-demosaic decimation.
- `DATA_W`, default 12: channel width.

Ports:
- `iCLK`, in, 1: clock.
- `iRST`, in, 1: reset. Asynchronous, active-low.
- `iRed`, `iGreen`, `iBlue`, in, 12 each: demosaiced pixel.
- `iDVAL`, in, 1: pixel valid. Qualifies every input pixel.
- `iX_Cont`, `iY_Cont`, in, 11 each: sensor coordinates. Only the frame-start condition is used, both 0 with `iDVAL` low or high.
- `iEdgeDetect`, in, 1: 1 selects Sobel output; 0 selects bypass.
- `iIsHorizontalEdge`, in, 1: 1 selects the horizontal-edge kernel; 0 selects the vertical-edge kernel.
- `oRed`, `oGreen`, `oBlue`, out, 12 each: output pixel.
- `oDVAL`, out, 1: output valid.

## Operation
- Luma: Y = (R + 2G + B) >> 2. Use a 14-bit sum and keep bits [13:2].
- Column counter `col` (0..LINE_WIDTH-1) and row counter `row` (11-bit) advance only on `iDVAL`.
  - `col` wraps LINE_WIDTH-1 → 0 and increments `row`.
  - `row` saturates at 2047.
- Frame start: a cycle with `iX_Cont`==0 and `iY_Cont`==0 synchronously clears `col` and `row`.
  - The same cycle latches `iEdgeDetect` and `iIsHorizontalEdge` into mode registers.
  - Mode changes therefore never tear a frame.
  - If that cycle also has `iDVAL`, the pixel is counted as (0,0).
- Line buffers: two LINE_WIDTH-deep Y delay lines, shifted on `iDVAL`. They provide Y at rows r, r-1 and r-2 for column c.
- Window: a 3x3 register array p[row 0..2][col 0..2], shifted on `iDVAL`. Row 0 is the oldest line; col 2 is the newest pixel. The window centre is pixel (r-1, c-1).
- Horizontal kernel: G = (p00 + 2p01 + p02) - (p20 + 2p21 + p22).
- Vertical kernel: G = (p02 + 2p12 + p22) - (p00 + 2p10 + p20).
- G is a 15-bit signed value; |G| ≤ 16380.
- Output value = min(|G|, 4095), driven on all three channels.
- Border: when the window is incomplete (`row` < 2 or `col` < 2 at window load), the output value is forced to 0. Line-buffer contents are never reset; this masking makes them irrelevant.
- Bypass (latched mode 0): the input RGB travels through a delay matching the Sobel latency. Sobel datapath activity is ignored.

## Timing
- Fixed latency of 3 cycles, `iDVAL` → `oDVAL`.
  - Stage 1: luma and window shift.
  - Stage 2: kernel sums.
  - Stage 3: abs and saturate.
- `oDVAL` is `iDVAL` delayed exactly 3 cycles, in every mode and including border pixels.
- Pipeline registers advance every cycle. Bubbles (`iDVAL` low) propagate as `oDVAL` low; data on those cycles is don't-care.
- Reset values: all outputs 0, `oDVAL` 0, counters 0, mode registers 0 (bypass, vertical kernel).
- Reset mid-frame clears the pipeline immediately. The next pixel is treated as (0,0) until a real frame start arrives.
- Frame start coincident with a line wrap: the frame-start clear wins.

## Structure
- Shared package `sobel_pkg`:
  - `DATA_W`
  - luma width (14)
  - gradient width (15, signed)
  - `SAT_MAX` = 4095
  - kernel-select enum `{KERN_VERT, KERN_HORZ}`
- Sub-module `sobel_line_buffer`: parameterised LINE_WIDTH×12 shift-register delay line with clock enable and one tap. It is instantiated twice and maps to M10K.

## Test plan
- Reset: assert `iRST`=0 mid-stream → all outputs 0 asynchronously. After release, the first valid pixel yields `oDVAL` exactly 3 cycles later.
- Bypass: `iEdgeDetect`=0 latched, R=100, G=200, B=300 on a valid cycle → 3 cycles later `oRed`/`oGreen`/`oBlue` = 100/200/300 with `oDVAL`=1. Bubbles are preserved.
- Flat field: R=G=B=1000, either kernel → every output 0, including interior pixels.
- Vertical step: columns ≥ 320 = 4095, else 0; vertical kernel.
  - Centres at columns 319 and 320 (rows ≥ 1) output 4095 (|G|=16380 saturated).
  - All other pixels output 0.
  - The horizontal kernel on the same image outputs all 0.
- Horizontal step: rows ≥ 240 = 1000, else 0; horizontal kernel.
  - Centre rows 239 and 240 output 4000.
  - Rows 0–1 and columns 0–1 of each line output 0.
- Mode latch: toggle `iIsHorizontalEdge` mid-frame → the current frame keeps its kernel. The change takes effect only after the next (0,0) coordinate.
